// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//
// Program-counter sequencer for the MIPS core. It holds the PC register and
// picks the next PC from the sequential, branch, jump and jump-register
// sources. A blocking syscall parks the core in HALT until the operator gives
// a fresh rising edge on Go. Retired-instruction, RUN-cycle and
// control-transfer counters are kept for the board display.
//
// Parameters
//   ADDR_W    : PC width (jump-field arithmetic keeps pc_plus_4[ADDR_W-1:28])
//   RESET_PC  : PC value loaded on reset
//   PASS_CODE : syscall service code that does not halt
//   CNT_W     : width of each statistics counter
//
// Ports
//   clk          in   single clock, rising edge
//   rst          in   synchronous active-high reset
//   stall        in   external hold; freezes PC, FSM and retire counting in RUN
//   Syscall      in   current instruction is syscall
//   R1_out       in   syscall service code ($v0)
//   Go           in   operator resume button (level)
//   branch_taken in   conditional branch resolved taken
//   ext18        in   sign-extended, <<2 branch offset
//   Jmp          in   j / jal
//   instr_index  in   26-bit jump target field
//   Jr           in   jr / jalr
//   jr_addr      in   register jump target
//   pc           out  current PC
//   pc_plus_4    out  pc + 4 (combinational, link value)
//   halted       out  FSM is in HALT
//   misalign     out  sticky: a misaligned jr target was taken
//   cycle_cnt    out  cycles spent in RUN (stalled or not)
//   retired_cnt  out  PC advances (retired instructions)
//   xfer_cnt     out  taken branches, jumps and jr
// -----------------------------------------------------------------------------
module pc_sequencer #(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter logic [31:0]       PASS_CODE = 32'h0000_0022,
    parameter int unsigned       CNT_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              Syscall,
    input  logic [31:0]       R1_out,
    input  logic              Go,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] ext18,
    input  logic              Jmp,
    input  logic [25:0]       instr_index,
    input  logic              Jr,
    input  logic [ADDR_W-1:0] jr_addr,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus_4,
    output logic              halted,
    output logic              misalign,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [CNT_W-1:0]  retired_cnt,
    output logic [CNT_W-1:0]  xfer_cnt
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    // A jump keeps only the PC bits above the 28-bit region addressed by
    // {instr_index, 2'b00}.
    localparam logic [ADDR_W-1:0] JMP_KEEP_MASK = ~ADDR_W'(28'hFFF_FFFF);

    state_t            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic              go_q;
    logic              misalign_q;
    logic [CNT_W-1:0]  cycle_q;
    logic [CNT_W-1:0]  retired_q;
    logic [CNT_W-1:0]  xfer_q;

    logic [ADDR_W-1:0] pc_plus_4_w;
    logic [ADDR_W-1:0] jmp_target;
    logic [ADDR_W-1:0] jr_target;
    logic [ADDR_W-1:0] next_pc_d;
    logic              jr_misaligned;
    logic              blocking_sys;
    logic              go_rise;
    logic              xfer_taken;

    assign pc_plus_4_w   = pc_q + ADDR_W'(4);
    assign jmp_target    = (pc_plus_4_w & JMP_KEEP_MASK) | ADDR_W'({instr_index, 2'b00});
    assign jr_target     = {jr_addr[ADDR_W-1:2], 2'b00};
    assign jr_misaligned = |jr_addr[1:0];
    assign blocking_sys  = Syscall && (R1_out != PASS_CODE);
    // Release needs a fresh low->high edge; a Go already high on entry to
    // HALT, or held high afterwards, never releases.
    assign go_rise       = Go & ~go_q;
    assign xfer_taken    = Jr | Jmp | branch_taken;

    // Fixed priority: jr, then jump, then taken branch, then sequential.
    always_comb begin
        next_pc_d = pc_plus_4_w;
        if (Jr) begin
            next_pc_d = jr_target;
        end else if (Jmp) begin
            next_pc_d = jmp_target;
        end else if (branch_taken) begin
            next_pc_d = pc_plus_4_w + ext18;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            pc_q       <= RESET_PC;
            go_q       <= 1'b0;
            misalign_q <= 1'b0;
            cycle_q    <= '0;
            retired_q  <= '0;
            xfer_q     <= '0;
        end else begin
            go_q <= Go;
            case (state_q)
                ST_RUN: begin
                    cycle_q <= cycle_q + CNT_W'(1);
                    if (!stall) begin
                        if (blocking_sys) begin
                            // PC stays on the syscall; it retires on release.
                            state_q <= ST_HALT;
                        end else begin
                            pc_q      <= next_pc_d;
                            retired_q <= retired_q + CNT_W'(1);
                            if (xfer_taken) begin
                                xfer_q <= xfer_q + CNT_W'(1);
                            end
                            if (Jr && jr_misaligned) begin
                                misalign_q <= 1'b1;
                            end
                        end
                    end
                end
                ST_HALT: begin
                    // stall is deliberately ignored while halted.
                    if (go_rise) begin
                        pc_q      <= pc_plus_4_w;
                        retired_q <= retired_q + CNT_W'(1);
                        state_q   <= ST_RUN;
                    end
                end
                default: begin
                    state_q <= ST_RUN;
                end
            endcase
        end
    end

    assign pc          = pc_q;
    assign pc_plus_4   = pc_plus_4_w;
    assign halted      = (state_q == ST_HALT);
    assign misalign    = misalign_q;
    assign cycle_cnt   = cycle_q;
    assign retired_cnt = retired_q;
    assign xfer_cnt    = xfer_q;

endmodule
